// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: in-order instruction FIFO that stamps each accepted word with its fetch PC.
// Revision 1.0 - initial release.
`timescale 1ns/1ps
`default_nettype none

module inst_fetch_queue #(
  parameter int               XLEN     = 64,
  parameter int               ILEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ILEN-1:0]          in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ILEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic [XLEN-1:0]          fetch_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              AW   = $clog2(DEPTH);
  localparam int              CW   = AW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  logic [ILEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            enq;
  logic            deq;

  // Redirect targets are word aligned; the low bits are intentionally dropped.
  logic unused_redirect_bits;
  assign unused_redirect_bits = &{1'b0, redirect_pc[1:0]};

  assign in_ready  = (count != FULL) && !redirect_valid;
  assign out_valid = (count != '0);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;

  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      // A same-cycle dequeue is still consumed by the datapath; the flush wins.
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      if (enq) begin
        wr_ptr   <= wr_ptr + AW'(1);
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire
